// File: rtl/spi_sched_pkg.sv
// Shared types and constants for the SPI transfer scheduler.
//   state_t         : scheduler FSM state encoding
//   CLK_DIV_W_DEF   : default width of the spi_master clock divider
//   MODE0..MODE3    : SPI modes encoded as {cpol, cpha}
package spi_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

    localparam int unsigned CLK_DIV_W_DEF = 16;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping around. The caller owns and advances the pointer.
//   req     in  NUM_REQ  request vector
//   ptr     in  PTR_W    highest-priority index for this pick
//   any     out 1        at least one request asserted
//   gnt_oh  out NUM_REQ  one-hot winner (zero when no request)
//   gnt_idx out PTR_W    binary winner index (zero when no request)
module spi_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               any,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [PTR_W-1:0]   gnt_idx
);

    // Walk positions ptr, ptr+1, ... (mod NUM_REQ); first hit wins.
    always_comb begin
        int unsigned pos;
        any     = 1'b0;
        gnt_oh  = '0;
        gnt_idx = '0;
        pos     = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            pos = 32'(ptr) + off;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (!any && req[PTR_W'(pos)]) begin
                any                  = 1'b1;
                gnt_oh[PTR_W'(pos)]  = 1'b1;
                gnt_idx              = PTR_W'(pos);
            end
        end
    end

endmodule

// File: rtl/spi_xfer_scheduler.sv
// Shares one spi_master among NUM_REQ requesters, round-robin. The winner's
// mode and divider are applied, allowed to settle for SETUP_CYCLES, then a
// start pulse is issued; the received word is returned with a one-cycle
// rsp_valid. Chip selects are the master's ss_n gated by the grant.
//   clk, rst                      clock, async active-high reset
//   req/req_tx/req_cpol/req_cpha/req_clk_div   requester side
//   gnt, rsp_valid, rsp_rx, busy  status back to requesters
//   m_*                           spi_master interface
//   cs_n                          per-slave active-low chip select
module spi_xfer_scheduler
    import spi_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLK_DIV_W    = CLK_DIV_W_DEF,
    parameter int unsigned SETUP_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 8,
    parameter int unsigned RST_CLK_DIV  = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_tx,
    input  logic [NUM_REQ-1:0]              req_cpol,
    input  logic [NUM_REQ-1:0]              req_cpha,
    input  logic [NUM_REQ*CLK_DIV_W-1:0]    req_clk_div,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rx,
    output logic                            busy,
    output logic                            m_start,
    output logic [DATA_WIDTH-1:0]           m_tx_byte,
    output logic                            m_cpol,
    output logic                            m_cpha,
    output logic [CLK_DIV_W-1:0]            m_clk_div,
    input  logic                            m_busy,
    input  logic                            m_done,
    input  logic [DATA_WIDTH-1:0]           m_rx_byte,
    input  logic                            m_ss_n,
    output logic [NUM_REQ-1:0]              cs_n
);

    localparam int unsigned PTR_W   = $clog2(NUM_REQ);
    localparam int unsigned CNT_MAX = (SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_t                 state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic [PTR_W-1:0]       ptr, ptr_d, ptr_nxt;
    logic [NUM_REQ-1:0]     gnt_d, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_rx_d, tx_d;
    logic                   busy_d, m_start_d, cpol_d, cpha_d;
    logic [CLK_DIV_W-1:0]   div_d;

    logic                   arb_any;
    logic [NUM_REQ-1:0]     arb_oh;
    logic [PTR_W-1:0]       arb_idx;

    logic [DATA_WIDTH-1:0]  sel_tx;
    logic                   sel_cpol, sel_cpha;
    logic [CLK_DIV_W-1:0]   sel_div;

    // Master busy is implied by the FSM sequencing; completion comes from m_done.
    logic unused_m_busy;
    assign unused_m_busy = m_busy;

    // Only the granted slave can ever see the master's ss_n low.
    assign cs_n = {NUM_REQ{m_ss_n}} | ~gnt;

    spi_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req     (req),
        .ptr     (ptr),
        .any     (arb_any),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx)
    );

    assign ptr_nxt = (arb_idx == PTR_W'(NUM_REQ - 1)) ? '0 : arb_idx + PTR_W'(1);

    // Mux the winner's transfer word and configuration.
    always_comb begin
        sel_tx   = '0;
        sel_cpol = 1'b0;
        sel_cpha = 1'b0;
        sel_div  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_oh[i]) begin
                sel_tx   = req_tx[i*DATA_WIDTH +: DATA_WIDTH];
                sel_cpol = req_cpol[i];
                sel_cpha = req_cpha[i];
                sel_div  = req_clk_div[i*CLK_DIV_W +: CLK_DIV_W];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        ptr_d       = ptr;
        gnt_d       = gnt;
        rsp_valid_d = '0;
        rsp_rx_d    = rsp_rx;
        m_start_d   = 1'b0;
        tx_d        = m_tx_byte;
        cpol_d      = m_cpol;
        cpha_d      = m_cpha;
        div_d       = m_clk_div;

        case (state)
            ST_IDLE: begin
                // Config is only loaded here, when every cs_n is high.
                if (arb_any) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                    ptr_d   = ptr_nxt;
                    gnt_d   = arb_oh;
                    tx_d    = sel_tx;
                    cpol_d  = sel_cpol;
                    cpha_d  = sel_cpha;
                    div_d   = sel_div;
                end
            end
            ST_SETUP: begin
                if (cnt == CNT_W'(SETUP_CYCLES - 1)) begin
                    state_d   = ST_START;
                    m_start_d = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_START: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // Leaving on the first done cycle makes a held done harmless.
                if (m_done) begin
                    state_d     = ST_GAP;
                    cnt_d       = '0;
                    rsp_valid_d = gnt;
                    rsp_rx_d    = m_rx_byte;
                end
            end
            ST_GAP: begin
                if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ptr       <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_rx    <= '0;
            busy      <= 1'b0;
            m_start   <= 1'b0;
            m_tx_byte <= '0;
            {m_cpol, m_cpha} <= MODE0;
            m_clk_div <= CLK_DIV_W'(RST_CLK_DIV);
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            ptr       <= ptr_d;
            gnt       <= gnt_d;
            rsp_valid <= rsp_valid_d;
            rsp_rx    <= rsp_rx_d;
            busy      <= busy_d;
            m_start   <= m_start_d;
            m_tx_byte <= tx_d;
            m_cpol    <= cpol_d;
            m_cpha    <= cpha_d;
            m_clk_div <= div_d;
        end
    end

endmodule

// File: tb/tb_spi_xfer_scheduler.sv
// Directed bench for spi_xfer_scheduler with a behavioural spi_master/slave model.
module tb_spi_xfer_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_tx;
    logic [3:0]  req_cpol;
    logic [3:0]  req_cpha;
    logic [63:0] req_clk_div;
    logic [3:0]  gnt;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_rx;
    logic        busy;
    logic        m_start;
    logic [7:0]  m_tx_byte;
    logic        m_cpol;
    logic        m_cpha;
    logic [15:0] m_clk_div;
    logic        m_busy;
    logic        m_done;
    logic [7:0]  m_rx_byte;
    logic        m_ss_n;
    logic [3:0]  cs_n;

    int n_cmp = 0;
    int n_err = 0;

    spi_xfer_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_tx      (req_tx),
        .req_cpol    (req_cpol),
        .req_cpha    (req_cpha),
        .req_clk_div (req_clk_div),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_rx      (rsp_rx),
        .busy        (busy),
        .m_start     (m_start),
        .m_tx_byte   (m_tx_byte),
        .m_cpol      (m_cpol),
        .m_cpha      (m_cpha),
        .m_clk_div   (m_clk_div),
        .m_busy      (m_busy),
        .m_done      (m_done),
        .m_rx_byte   (m_rx_byte),
        .m_ss_n      (m_ss_n),
        .cs_n        (cs_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // spi_master + slaves model: transfer lasts 2*clk_div cycles, then done pulses.
    logic [15:0] mcnt;
    logic [7:0]  mtx;
    logic [7:0]  slave_tx [4];
    logic [7:0]  slave_rx [4];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ss_n    <= 1'b1;
            m_busy    <= 1'b0;
            m_done    <= 1'b0;
            m_rx_byte <= 8'h00;
            mcnt      <= 16'd0;
            mtx       <= 8'h00;
        end else begin
            m_done <= 1'b0;
            if (!m_busy && m_start) begin
                m_busy <= 1'b1;
                m_ss_n <= 1'b0;
                mcnt   <= {m_clk_div[14:0], 1'b0};
                mtx    <= m_tx_byte;
            end else if (m_busy) begin
                if (mcnt <= 16'd1) begin
                    m_busy <= 1'b0;
                    m_ss_n <= 1'b1;
                    m_done <= 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        if (!cs_n[i]) m_rx_byte <= slave_tx[i];
                    end
                end else begin
                    mcnt <= mcnt - 16'd1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && m_busy && mcnt <= 16'd1) begin
            for (int i = 0; i < 4; i++) begin
                if (!cs_n[i]) slave_rx[i] <= mtx;
            end
        end
    end

    // Negedge monitors: config stability, gaps, busy low runs, response counts.
    int          rsp_cnt [4];
    int          cfg_viol = 0;
    int          oh_viol = 0;
    int          gap_run = 0;
    int          last_gap = 0;
    int          busy_low_run = 0;
    int          last_busy_low = 0;
    int          cfg_stable = 0;
    int          last_settle = 0;
    logic        prev_any_low = 1'b0;
    logic        prev_busy = 1'b0;
    logic [17:0] prev_cfg = 18'd0;

    always @(negedge clk) begin
        logic [17:0] cfg;
        logic        any_low;
        cfg     = {m_cpol, m_cpha, m_clk_div};
        any_low = (cs_n != 4'hF);
        if (any_low && cfg != prev_cfg) cfg_viol++;
        if (cfg != prev_cfg) cfg_stable = 0;
        else cfg_stable++;
        if (any_low && !prev_any_low) begin
            last_settle = cfg_stable;
            last_gap    = gap_run;
        end
        if (any_low) gap_run = 0;
        else gap_run++;
        if ($countones(~cs_n) > 1 || $countones(gnt) > 1) oh_viol++;
        if (busy && !prev_busy) last_busy_low = busy_low_run;
        if (busy) busy_low_run = 0;
        else busy_low_run++;
        for (int i = 0; i < 4; i++) begin
            if (rst) rsp_cnt[i] = 0;
            else if (rsp_valid[i]) rsp_cnt[i]++;
        end
        prev_cfg     = cfg;
        prev_any_low = any_low;
        prev_busy    = busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] tx, input logic cp,
                           input logic ch, input logic [15:0] div);
        req_tx[i*8 +: 8]       = tx;
        req_cpol[i]            = cp;
        req_cpha[i]            = ch;
        req_clk_div[i*16 +: 16] = div;
    endtask

    task automatic wait_rsp(input string tag);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (rsp_valid != 4'h0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_rsp_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_idle_seen"}, 32'(ok), 32'd1);
    endtask

    function automatic int oh2idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial begin
        int cyc;
        int idx;
        int exp_seq [4];

        rst = 1'b1;
        req = 4'h0;
        req_tx = '0;
        req_cpol = '0;
        req_cpha = '0;
        req_clk_div = {4{16'd10}};
        for (int i = 0; i < 4; i++) slave_tx[i] = 8'h00;

        // Reset values
        repeat (3) tick();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_cs_n", 32'(cs_n), 32'hF);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_m_start", 32'(m_start), 32'h0);
        check("rst_m_clk_div", 32'(m_clk_div), 32'd10);
        check("rst_rsp_rx", 32'(rsp_rx), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_m_tx", 32'(m_tx_byte), 32'h0);
        check("rst_mode", 32'({m_cpol, m_cpha}), 32'h0);
        rst = 1'b0;
        tick();

        // 1: single transfer on requester 0
        set_req(0, 8'hA5, 1'b0, 1'b0, 16'd10);
        slave_tx[0] = 8'h5A;
        req = 4'b0001;
        cyc = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                check("t1_gnt", 32'(gnt), 32'h1);
                check("t1_busy", 32'(busy), 32'h1);
                check("t1_m_tx", 32'(m_tx_byte), 32'hA5);
                check("t1_m_clk_div", 32'(m_clk_div), 32'd10);
            end
            if (m_start) break;
        end
        check("t1_start_latency", 32'(cyc), 32'd5);
        tick();
        check("t1_start_one_cycle", 32'(m_start), 32'h0);
        check("t1_cs_n", 32'(cs_n), 32'hE);
        wait_rsp("t1");
        check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        check("t1_rsp_rx", 32'(rsp_rx), 32'h5A);
        req = 4'h0;
        tick();
        check("t1_rsp_pulse_end", 32'(rsp_valid), 32'h0);
        check("t1_rsp_rx_held", 32'(rsp_rx), 32'h5A);
        check("t1_slave_rx", 32'(slave_rx[0]), 32'hA5);
        wait_idle("t1");

        // 2: all four at once after reset -> served 0,1,2,3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 8'((i + 1) * 17), 1'b0, 1'b0, 16'd10);
            slave_tx[i] = 8'(8'hC0 + i);
        end
        req = 4'hF;
        for (int t = 0; t < 4; t++) begin
            wait_rsp("t2");
            idx = oh2idx(rsp_valid);
            check("t2_order", 32'(idx), 32'(t));
            check("t2_rsp_rx", 32'(rsp_rx), 32'(8'hC0 + t));
            if (idx >= 0) req[idx] = 1'b0;
        end
        wait_idle("t2");
        for (int i = 0; i < 4; i++) begin
            check("t2_slave_rx", 32'(slave_rx[i]), 32'((i + 1) * 17));
            check("t2_rsp_count", 32'(rsp_cnt[i]), 32'd1);
        end

        // 3: requesters 1 and 3 held -> 1,3,1,3 back to back
        exp_seq[0] = 1; exp_seq[1] = 3; exp_seq[2] = 1; exp_seq[3] = 3;
        req = 4'b1010;
        for (int t = 0; t < 4; t++) begin
            wait_rsp("t3");
            check("t3_order", 32'(oh2idx(rsp_valid)), 32'(exp_seq[t]));
            if (t == 3) req = 4'h0;
        end
        wait_idle("t3");
        // 5: back-to-back spacing: 1 rsp + 8 gap + 1 idle + 4 setup + 1 start
        check("t5_cs_gap", 32'(last_gap), 32'd15);
        check("t5_busy_low", 32'(last_busy_low), 32'd1);

        // 4: mode3/div4 then mode0/div10
        slave_tx[0] = 8'h96;
        slave_tx[1] = 8'h87;
        set_req(0, 8'h3C, 1'b1, 1'b1, 16'd4);
        set_req(1, 8'h69, 1'b0, 1'b0, 16'd10);
        req = 4'b0011;
        tick();
        check("t4_gnt0", 32'(gnt), 32'h1);
        check("t4_mode3", 32'({m_cpol, m_cpha}), 32'h3);
        check("t4_div4", 32'(m_clk_div), 32'd4);
        wait_rsp("t4a");
        check("t4_first", 32'(rsp_valid), 32'h1);
        check("t4_rx0", 32'(rsp_rx), 32'h96);
        check("t4_settle0", 32'(last_settle >= 4), 32'd1);
        req[0] = 1'b0;
        wait_rsp("t4b");
        check("t4_second", 32'(rsp_valid), 32'h2);
        check("t4_rx1", 32'(rsp_rx), 32'h87);
        check("t4_settle1", 32'(last_settle >= 4), 32'd1);
        check("t4_mode0", 32'({m_cpol, m_cpha}), 32'h0);
        check("t4_div10", 32'(m_clk_div), 32'd10);
        req[1] = 1'b0;
        wait_idle("t4");
        check("t4_slave_rx0", 32'(slave_rx[0]), 32'h3C);
        check("t4_slave_rx1", 32'(slave_rx[1]), 32'h69);

        // 6: reset during WAIT_DONE, request kept asserted
        slave_tx[2] = 8'hF5;
        set_req(2, 8'h5F, 1'b0, 1'b0, 16'd10);
        req = 4'b0100;
        cyc = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            cyc++;
            if (m_start) break;
        end
        check("t6_start_latency", 32'(cyc), 32'd5);
        repeat (3) tick();
        check("t6_cs_before", 32'(cs_n), 32'hB);
        rst = 1'b1;
        #1;
        check("t6_rst_gnt", 32'(gnt), 32'h0);
        check("t6_rst_cs_n", 32'(cs_n), 32'hF);
        check("t6_rst_busy", 32'(busy), 32'h0);
        check("t6_rst_m_start", 32'(m_start), 32'h0);
        check("t6_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("t6_rst_m_clk_div", 32'(m_clk_div), 32'd10);
        repeat (2) tick();
        check("t6_rst_no_rsp", 32'(rsp_valid), 32'h0);
        rst = 1'b0;
        wait_rsp("t6");
        check("t6_rsp_valid", 32'(rsp_valid), 32'h4);
        check("t6_rsp_rx", 32'(rsp_rx), 32'hF5);
        req = 4'h0;
        wait_idle("t6");
        check("t6_slave_rx", 32'(slave_rx[2]), 32'h5F);
        check("t6_rsp_count", 32'(rsp_cnt[2]), 32'd1);

        check("cfg_change_while_cs_low", 32'(cfg_viol), 32'd0);
        check("onehot_gnt_cs", 32'(oh_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_xfer_scheduler.md
Name: spi_xfer_scheduler

Overview:
Round-robin scheduler that shares one spi_master among NUM_REQ requesters, each owning one SPI slave. It applies the granted requester's mode (cpol/cpha) and clk_div before every transfer, then pulses start and collects rx_byte. It also generates a per-slave active-low chip select from the master's ss_n. It sits between the on-chip clients and the spi_master instance.

Parameters:
NUM_REQ, 4, number of requesters/slaves (>=2)
DATA_WIDTH, 8, SPI word width, matches spi_master
CLK_DIV_W, 16, width of clk_div
SETUP_CYCLES, 4, cycles config is applied before start; sclk idle level settles (>=1)
GAP_CYCLES, 8, minimum cycles all cs_n held high between transfers (>=1)
RST_CLK_DIV, 10, m_clk_div value after reset

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester transfer request (level)
req_tx  in  NUM_REQ*DATA_WIDTH  packed tx words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_cpol  in  NUM_REQ  per-requester CPOL
req_cpha  in  NUM_REQ  per-requester CPHA
req_clk_div  in  NUM_REQ*CLK_DIV_W  packed per-requester clk_div
gnt  out  NUM_REQ  one-hot grant, held SETUP through GAP
rsp_valid  out  NUM_REQ  one-cycle completion pulse to served requester
rsp_rx  out  DATA_WIDTH  received word, valid with rsp_valid, held until next capture
busy  out  1  high whenever state != IDLE
m_start  out  1  start pulse to spi_master
m_tx_byte  out  DATA_WIDTH  tx word to spi_master
m_cpol  out  1  mode to spi_master
m_cpha  out  1  mode to spi_master
m_clk_div  out  CLK_DIV_W  half-period divider to spi_master
m_busy  in  1  spi_master busy
m_done  in  1  spi_master done
m_rx_byte  in  DATA_WIDTH  spi_master rx_byte
m_ss_n  in  1  spi_master ss_n
cs_n  out  NUM_REQ  per-slave chip select, active low

Behaviour:
- Reset (async, immediate): state IDLE, gnt=0, rsp_valid=0, rsp_rx=0, busy=0, m_start=0, m_tx_byte=0, m_cpol=0, m_cpha=0, m_clk_div=RST_CLK_DIV, rr pointer=0. cs_n all 1.
- cs_n[i] = m_ss_n | ~gnt[i] (combinational). Only the granted slave can ever see ss_n low.
- States: IDLE, SETUP, START, WAIT_DONE, GAP.
- IDLE: if any req, pick the first asserted index at or after the rr pointer (wrapping). Next edge: register gnt, m_tx_byte, m_cpol, m_cpha, m_clk_div from the winner; go SETUP. The rr pointer becomes winner+1 mod NUM_REQ.
- SETUP: count SETUP_CYCLES cycles, then START. m_* config changes only on IDLE->SETUP, never while any cs_n is low.
- START: m_start=1 for exactly one cycle; go WAIT_DONE.
- WAIT_DONE: on the first cycle m_done=1, capture m_rx_byte into rsp_rx and pulse rsp_valid[winner] on the next cycle; go GAP. A sustained m_done level is tolerated.
- GAP: hold gnt for GAP_CYCLES cycles, then clear gnt and go IDLE. A new arbitration may occur in that same IDLE cycle.
- Latency req->m_start: 1+SETUP_CYCLES cycles. m_done->rsp_valid: 1 cycle.
- Requester rules: hold req_tx and config stable from req until rsp_valid. Dropping req while granted does not abort the transfer; rsp_valid still pulses. req still high after rsp_valid is a new request.
- Simultaneous requests: served strictly round-robin. No requester waits more than NUM_REQ-1 transfers.
- Reset mid-transfer: all outputs return to reset values at once. spi_master shares rst. Pending requests are re-arbitrated from pointer 0 after release.

Decomposition:
- Package spi_sched_pkg: state encoding localparams, CLK_DIV_W default, SPI mode constants (MODE0..MODE3 as {cpol,cpha}).
- Sub-module spi_rr_arbiter (NUM_REQ): combinational rotate/priority pick from req and pointer, plus one-hot and index outputs. Scheduler owns the pointer register.

Test Plan:
1. req[0], tx A5, mode0, clk_div 10, slave0 tx 5A -> cs_n=1110 during transfer, m_start after 5 cycles, rsp_valid[0] pulse with rsp_rx=5A, slave0 rx=A5.
2. req=1111 at once, tx 11/22/33/44 -> served in order 0,1,2,3, each rsp_valid exactly once, slaves receive matching bytes.
3. req[1] and req[3] held continuously -> grants alternate 1,3,1,3 across 4 transfers. rr pointer correct after wrap.
4. req0 mode3 clk_div 4, then req1 mode0 clk_div 10 -> m_cpol/m_cpha/m_clk_div change only with all cs_n high. sclk at new idle level >=SETUP_CYCLES cycles before cs_n falls. Both words correct.
5. Back-to-back transfers -> all cs_n high for >=GAP_CYCLES cycles between transfers. busy low for exactly one cycle or more between them.
6. rst asserted mid-WAIT_DONE -> same-cycle gnt=0, cs_n=1111, busy=0, m_start=0, no rsp_valid. After release, a still-held req completes normally.
